// File: rtl/sd_spi_master_pkg.sv
// Shared types and default bit-rate divisors for the SD-card SPI byte master.
package sd_spi_master_pkg;

  typedef enum logic [2:0] {
    SPI_IDLE  = 3'd0,
    SPI_SETUP = 3'd1,
    SPI_LOW   = 3'd2,
    SPI_HIGH  = 3'd3,
    SPI_DONE  = 3'd4
  } sd_spi_state_t;

  localparam int SD_SPI_FAST_DIV = 2;
  localparam int SD_SPI_SLOW_DIV = 64;

endpackage

// File: rtl/sd_spi_master_timer.sv
// Loadable down-counter that times one SCK half-period; expired while the count sits at zero.
module spi_half_period_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 master for the SD slot: MSB first, slow/fast SCK, chip select held across a byte.
module sd_spi_master
  import sd_spi_master_pkg::*;
#(
  parameter int FAST_DIV = SD_SPI_FAST_DIV,
  parameter int SLOW_DIV = SD_SPI_SLOW_DIV
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx,
  input  logic       rx,
  input  logic [7:0] data_to_SD,
  output logic [7:0] data_from_SD,
  input  logic       ss_req,
  input  logic       slow,
  output logic       busy,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_ss,
  output logic       spi_enable
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CNT_W   = $clog2(MAX_DIV + 1);

  localparam logic [CNT_W-1:0] FAST_VAL = CNT_W'(FAST_DIV);
  localparam logic [CNT_W-1:0] SLOW_VAL = CNT_W'(SLOW_DIV);

  localparam logic [2:0] ST_IDLE  = SPI_IDLE;
  localparam logic [2:0] ST_SETUP = SPI_SETUP;
  localparam logic [2:0] ST_LOW   = SPI_LOW;
  localparam logic [2:0] ST_HIGH  = SPI_HIGH;
  localparam logic [2:0] ST_DONE  = SPI_DONE;

  logic [2:0]       state_q, state_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             busy_q, busy_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             ss_q, ss_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_expired;

  assign timer_value = div_q - CNT_W'(1);

  spi_half_period_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (timer_load),
    .value  (timer_value),
    .expired(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rdata_d    = rdata_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    busy_d     = busy_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    timer_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx || rx) begin
          tx_shift_d = tx ? data_to_SD : 8'hFF;
          div_d      = slow ? SLOW_VAL : FAST_VAL;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        mosi_d     = tx_shift_q[7];
        timer_load = 1'b1;
        state_d    = ST_LOW;
      end
      ST_LOW: begin
        // MISO is captured on the same edge that raises SCK
        if (timer_expired) begin
          sck_d      = 1'b1;
          rx_shift_d = {rx_shift_q[6:0], spi_miso};
          timer_load = 1'b1;
          state_d    = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (timer_expired) begin
          sck_d = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            tx_shift_d = {tx_shift_q[6:0], 1'b1};
            mosi_d     = tx_shift_q[6];
            timer_load = 1'b1;
            state_d    = ST_LOW;
          end
        end
      end
      ST_DONE: begin
        rdata_d = rx_shift_q;
        mosi_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Select is taken at once; release waits for idle so SS never rises inside a byte
  always_comb begin
    ss_d = ss_q;
    if (ss_req) begin
      ss_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      ss_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= 8'hFF;
      rx_shift_q <= 8'hFF;
      rdata_q    <= 8'hFF;
      bit_cnt_q  <= '0;
      div_q      <= FAST_VAL;
      busy_q     <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b1;
      ss_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rdata_q    <= rdata_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      busy_q     <= busy_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
    end
  end

  assign data_from_SD = rdata_q;
  assign busy         = busy_q;
  assign spi_clk      = sck_q;
  assign spi_mosi     = mosi_q;
  assign spi_ss       = ss_q;
  assign spi_enable   = busy_q | ~ss_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Self-checking bench for sd_spi_master: vector table plus hand sequences for SS deferral and reset abort.
module tb_sd_spi_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx;
  logic       rx;
  logic [7:0] data_to_SD;
  logic [7:0] data_from_SD;
  logic       ss_req;
  logic       slow;
  logic       busy;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_ss;
  logic       spi_enable;

  int n_compared = 0;
  int n_failed   = 0;

  logic [7:0] exp_q[$];

  typedef struct packed {
    logic        tx;
    logic        rx;
    logic [7:0]  data;
    logic [7:0]  miso;
    logic        slow;
    logic        toggle_slow;
    logic        extra_pulse;
    logic [7:0]  exp_mosi;
    logic [15:0] exp_busy;
  } vec_t;

  always #5 clk = ~clk;

  sd_spi_master #(
    .FAST_DIV(2),
    .SLOW_DIV(64)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx          (tx),
    .rx          (rx),
    .data_to_SD  (data_to_SD),
    .data_from_SD(data_from_SD),
    .ss_req      (ss_req),
    .slow        (slow),
    .busy        (busy),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_ss      (spi_ss),
    .spi_enable  (spi_enable)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_scoreboard(input string name);
    logic [7:0] exp_byte;
    if (exp_q.size() == 0) begin
      checkOutput({name, "_sb_empty"}, 1, 0);
    end else begin
      exp_byte = exp_q.pop_front();
      checkOutput({name, "_rdata"}, int'(data_from_SD), int'(exp_byte));
    end
  endtask

  // Drives one transfer and acts as the SPI slave: captures MOSI on rising SCK, shifts MISO on falling SCK
  task automatic applyStimulus(input vec_t v, output int busy_cycles, output int rises,
                               output logic [7:0] mosi_byte, output logic timed_out);
    logic [7:0] miso_bits;
    logic       prev_sck;
    miso_bits  = v.miso;
    spi_miso   = miso_bits[7];
    data_to_SD = v.data;
    tx         = v.tx;
    rx         = v.rx;
    slow       = v.slow;
    if (v.tx || v.rx) exp_q.push_back(v.miso);
    tick();
    tx          = 1'b0;
    rx          = 1'b0;
    busy_cycles = 0;
    rises       = 0;
    mosi_byte   = 8'h00;
    prev_sck    = 1'b0;
    timed_out   = 1'b0;
    while (busy === 1'b1) begin
      if (spi_clk && !prev_sck) begin
        mosi_byte = {mosi_byte[6:0], spi_mosi};
        rises++;
      end
      if (!spi_clk && prev_sck) begin
        miso_bits = {miso_bits[6:0], 1'b0};
        spi_miso  = miso_bits[7];
      end
      prev_sck = spi_clk;
      busy_cycles++;
      if (v.toggle_slow) slow = ~slow;
      if (v.extra_pulse) begin
        tx         = (busy_cycles == 5);
        data_to_SD = 8'h00;
      end
      if (busy_cycles > 3000) begin
        timed_out = 1'b1;
        break;
      end
      tick();
    end
    tx   = 1'b0;
    slow = 1'b0;
  endtask

  task automatic run_vector(input string name, input vec_t v);
    int         busy_cycles;
    int         rises;
    logic [7:0] mosi_byte;
    logic       timed_out;
    int         late_busy;
    applyStimulus(v, busy_cycles, rises, mosi_byte, timed_out);
    checkOutput({name, "_timeout"}, int'(timed_out), 0);
    checkOutput({name, "_busy_cycles"}, busy_cycles, int'(v.exp_busy));
    checkOutput({name, "_sck_rises"}, rises, 8);
    checkOutput({name, "_mosi"}, int'(mosi_byte), int'(v.exp_mosi));
    check_scoreboard(name);
    if (v.extra_pulse) begin
      late_busy = 0;
      for (int i = 0; i < 40; i++) begin
        if (busy !== 1'b0) late_busy++;
        tick();
      end
      checkOutput({name, "_no_second_byte"}, late_busy, 0);
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   guard;
    int   ss_high_busy;
    int   rises;
    logic prev_sck;
    logic ss_rose;

    //               tx    rx    data   miso   slow  tgl   xtra  mosi   busy
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0, 1'b0, 8'hA5, 16'd34};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hFF, 16'd34};
    vecs[2] = '{1'b1, 1'b1, 8'h12, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h12, 16'd34};
    vecs[3] = '{1'b1, 1'b0, 8'h6E, 8'h01, 1'b0, 1'b0, 1'b1, 8'h6E, 16'd34};
    vecs[4] = '{1'b1, 1'b0, 8'h81, 8'h7E, 1'b1, 1'b1, 1'b0, 8'h81, 16'd1026};
    vecs[5] = '{1'b1, 1'b0, 8'h81, 8'h99, 1'b0, 1'b0, 1'b0, 8'h81, 16'd34};

    reset_n    = 1'b0;
    tx         = 1'b0;
    rx         = 1'b0;
    data_to_SD = 8'h00;
    ss_req     = 1'b0;
    slow       = 1'b0;
    spi_miso   = 1'b1;
    repeat (3) tick();

    checkOutput("rst_spi_clk", int'(spi_clk), 0);
    checkOutput("rst_spi_mosi", int'(spi_mosi), 1);
    checkOutput("rst_spi_ss", int'(spi_ss), 1);
    checkOutput("rst_spi_enable", int'(spi_enable), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_data_from_sd", int'(data_from_SD), 8'hFF);

    reset_n = 1'b1;
    repeat (2) tick();

    $display("[TB] running vector table");
    for (int i = 0; i < 5; i++) begin
      run_vector($sformatf("vec%0d", i), vecs[i]);
      repeat (3) tick();
    end

    $display("[TB] chip-select deferral");
    checkOutput("ss_idle_high", int'(spi_ss), 1);
    ss_req = 1'b1;
    tick();
    checkOutput("ss_assert_next_cycle", int'(spi_ss), 0);
    checkOutput("enable_when_selected", int'(spi_enable), 1);
    spi_miso   = 1'b0;
    data_to_SD = 8'hC3;
    tx         = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    tx           = 1'b0;
    guard        = 0;
    ss_high_busy = 0;
    while (busy === 1'b1 && guard < 200) begin
      if (guard == 10) ss_req = 1'b0;
      if (spi_ss !== 1'b0) ss_high_busy++;
      guard++;
      tick();
    end
    checkOutput("ss_busy_timeout", int'(guard >= 200), 0);
    checkOutput("ss_held_during_byte", ss_high_busy, 0);
    check_scoreboard("ss_seq");
    ss_rose = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (spi_ss === 1'b1) begin
        ss_rose = 1'b1;
        break;
      end
    end
    checkOutput("ss_rises_after_done", int'(ss_rose), 1);
    checkOutput("enable_after_release", int'(spi_enable), 0);

    $display("[TB] reset in the middle of a byte");
    ss_req = 1'b1;
    repeat (2) tick();
    spi_miso   = 1'b0;
    data_to_SD = 8'h5A;
    tx         = 1'b1;
    tick();
    tx       = 1'b0;
    rises    = 0;
    prev_sck = 1'b0;
    guard    = 0;
    while (rises < 5 && guard < 200) begin
      if (spi_clk && !prev_sck) rises++;
      prev_sck = spi_clk;
      guard++;
      if (rises < 5) tick();
    end
    checkOutput("abort_reach_bit4", rises, 5);
    reset_n = 1'b0;
    tick();
    checkOutput("abort_spi_clk", int'(spi_clk), 0);
    checkOutput("abort_spi_mosi", int'(spi_mosi), 1);
    checkOutput("abort_spi_ss", int'(spi_ss), 1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_data_from_sd", int'(data_from_SD), 8'hFF);
    reset_n = 1'b1;
    ss_req  = 1'b0;
    repeat (2) tick();
    run_vector("post_abort", vecs[5]);

    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/sd_spi_master.md
Name: sd_spi_master

Overview:
- Byte-level SPI master sitting directly downstream of the MegaFlashROM SD device logic.
- Consumes the device side of the SD-card byte interface (`data_to_SD`, `rx`, `tx`) and returns the `data_from_SD` byte.
- Drives the physical SPI pins (`miso`/`mosi`/`clk`/`ss`/`enable`) toward the SD slot.
- One transfer = 8 bits, SPI mode 0, MSB first, with a selectable slow (card-init) or fast bit rate.

Parameters:
- `FAST_DIV`, 2, SPI half-period in `clk` cycles for normal operation (≥1).
- `SLOW_DIV`, 64, SPI half-period in `clk` cycles during card initialisation (≥1, keeps SCK < 400 kHz).

Ports:
- `clk` in 1 — system clock; all logic on rising edge.
- `reset_n` in 1 — synchronous, active-low reset.
- `tx` in 1 — one-cycle pulse: start transfer sending `data_to_SD`.
- `rx` in 1 — one-cycle pulse: start transfer sending 0xFF (read).
- `data_to_SD` in 8 — byte to send; sampled on the accepted `tx`.
- `data_from_SD` out 8 — last byte received from the card.
- `ss_req` in 1 — device requests card select (1 = selected).
- `slow` in 1 — 1 selects `SLOW_DIV`; sampled at transfer start.
- `busy` out 1 — transfer in progress.
- `spi_clk` out 1 — SCK.
- `spi_mosi` out 1 — MOSI.
- `spi_miso` in 1 — MISO.
- `spi_ss` out 1 — chip select, active low.
- `spi_enable` out 1 — pin drivers enabled; equals `busy` OR selected.

Behaviour:
- **Clock and reset.** One clock domain (`clk`); reset is synchronous, active-low `reset_n`.
  - Reset values: `spi_clk` = 0, `spi_mosi` = 1, `spi_ss` = 1, `spi_enable` = 0, `busy` = 0, `data_from_SD` = 0xFF, state = IDLE.
  - Reset mid-transfer aborts immediately. `data_from_SD` is not updated with the partial byte; it takes the reset value 0xFF.
- **States:** IDLE, SETUP, LOW, HIGH, DONE.
- **IDLE.**
  - `tx` or `rx` is accepted in IDLE only.
  - `tx` and `rx` in the same cycle: `tx` wins.
  - On accept, latch the shift register (`data_to_SD` for `tx`, 0xFF for `rx`), latch `div` = `slow` ? `SLOW_DIV` : `FAST_DIV`, and clear the bit counter (3 bit).
  - Go to SETUP; `busy` = 1 from the next cycle.
- **SETUP** (1 cycle): `spi_mosi` ← shift[7]. Go to LOW.
- **LOW.** `spi_clk` = 0 for `div` cycles, then → HIGH.
- **HIGH.**
  - On entry (rising SCK): sample `spi_miso` into rx_shift bit 0 (shift left).
  - Hold `spi_clk` = 1 for `div` cycles.
  - On exit (falling SCK): if bit counter = 7 → DONE. Otherwise increment the counter, shift the tx register left, update `spi_mosi` ← next MSB, → LOW.
- **DONE** (1 cycle):
  - `data_from_SD` ← rx_shift.
  - `spi_mosi` ← 1.
  - `busy` ← 0 at the end of the cycle. Return to IDLE.
- **Latency.** Accept to `busy` falling = 2 + 16·`div` cycles. `data_from_SD` is valid on the cycle `busy` is first 0, and holds until the next DONE.
- **Ignored inputs.** `tx`/`rx` while `busy` = 1 are ignored (no queue). `slow` changes mid-transfer have no effect.
- **Chip select.**
  - `spi_ss` = ~`ss_req`, registered.
  - Assertion takes effect next cycle at any time.
  - Deassertion during `busy` is deferred until DONE completes, so SS never rises mid-byte.
- **Divider.** Counter `div`−1 down to 0, reloaded on each LOW/HIGH entry. Width = $clog2(`SLOW_DIV`+1).
- **Idle MOSI.** `spi_mosi` idles at 1.

Decomposition:
- Shared package:
  - `sd_spi_state_t` enum {SPI_IDLE, SPI_SETUP, SPI_LOW, SPI_HIGH, SPI_DONE}.
  - Constants `SD_SPI_FAST_DIV` = 2 and `SD_SPI_SLOW_DIV` = 64, for use by top-level instantiation.
- Sub-module `spi_half_period_timer`:
  - Loadable down-counter with `load`, `value`, `expired`.
  - Used for LOW/HIGH timing.
- Everything else stays in `sd_spi_master`.

Test Plan:
- **Write byte.** `FAST_DIV`=2, `tx` with `data_to_SD`=0xA5 → MOSI sampled at the 8 SCK rising edges = 1,0,1,0,0,1,0,1; exactly 8 rising edges; `busy` high for 34 cycles.
- **Read byte.** `rx` with slave driving MISO = 0x3C MSB-first (changing on falling SCK) → MOSI constant 1; `data_from_SD`=0x3C when `busy` falls.
- **Slow mode.** `slow`=1, `SLOW_DIV`=64 → SCK high and low phases each 64 cycles; total `busy` 1026 cycles. Toggling `slow` mid-byte does not change timing.
- **Collisions.** `tx` and `rx` same cycle with `data_to_SD`=0x12 → 0x12 is shifted out. A second `tx` pulsed during `busy` → ignored: only one byte clocked, `busy` falls once.
- **SS deferral.** `ss_req` 0→1 before `tx` → `spi_ss` low next cycle. `ss_req` 1→0 mid-transfer → `spi_ss` stays 0 until after DONE, then rises.
- **Reset mid-transfer.** `reset_n`=0 during bit 4 → next cycle `spi_clk`=0, `spi_mosi`=1, `spi_ss`=1, `busy`=0, `data_from_SD`=0xFF. A subsequent `tx` of 0x81 completes normally.
